// File: rtl/host_mem_reader_pkg.sv
// Shared types and constants for the host memory line reader.
package host_mem_reader_pkg;

    localparam int MAX_BURST        = 4;
    localparam int LINE_COUNT_WIDTH = 32;

    typedef logic [LINE_COUNT_WIDTH-1:0] t_line_count;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } t_reader_state;

endpackage

// File: rtl/host_mem_reader_fifo.sv
// Response line buffer with a registered output stage; count includes the
// line sitting on the output register so it can be used directly for credits.
module host_mem_reader_fifo #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_WIDTH-1:0]  mem_count;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    logic pop;
    logic out_free;
    logic mem_empty;
    logic bypass;
    logic mem_wr;
    logic mem_rd;

    // An empty array feeds the output register straight from the write port,
    // giving one cycle from response beat to out_valid.
    always_comb begin
        pop       = out_valid_q & rd_ready;
        out_free  = ~out_valid_q | pop;
        mem_empty = (mem_count == '0);
        bypass    = wr_en & out_free & mem_empty;
        mem_wr    = wr_en & ~bypass;
        mem_rd    = out_free & ~mem_empty;
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_count   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (mem_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({mem_wr, mem_rd})
                2'b10:   mem_count <= mem_count + CNT_WIDTH'(1);
                2'b01:   mem_count <= mem_count - CNT_WIDTH'(1);
                default: mem_count <= mem_count;
            endcase
            if (out_free) begin
                out_valid_q <= mem_rd | bypass;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (out_free) begin
            if (mem_rd) begin
                out_data_q <= mem[rd_ptr];
            end else if (bypass) begin
                out_data_q <= wr_data;
            end
        end
    end

    assign rd_valid = out_valid_q;
    assign rd_data  = out_data_q;
    assign count    = mem_count + CNT_WIDTH'(out_valid_q);

endmodule

// File: rtl/host_mem_line_reader.sv
// Reads a run of host-memory cache lines over Avalon-MM and streams them out
// in order. Define HOST_MEM_READER_RSP_ERR_EN to flag error responses on err.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_REQ   | issuing bursts as buffer credits allow
// ST_DRAIN | all bursts accepted, streaming out remaining lines
// ST_DONE  | one-cycle completion pulse
module host_mem_line_reader
    import host_mem_reader_pkg::*;
#(
    parameter int ADDR_WIDTH      = 42,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 3,
    parameter int LEN_WIDTH       = $bits(t_line_count),
    parameter int BUF_LINES       = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic [LEN_WIDTH-1:0]    num_lines,
    output logic                    busy,
    output logic                    done,
    output logic                    err,

    output logic                    rd_read,
    output logic [ADDR_WIDTH-1:0]   rd_address,
    output logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
    output logic [DATA_WIDTH/8-1:0] rd_byteenable,
    output logic                    rd_user,
    input  logic                    rd_waitrequest,
    input  logic                    rd_readdatavalid,
    input  logic [DATA_WIDTH-1:0]   rd_readdata,
    input  logic [1:0]              rd_response,

    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    input  logic                    out_ready
);

    localparam int CNT_W  = $clog2(BUF_LINES) + 1;
    localparam int BOFF_W = $clog2(MAX_BURST);

    typedef logic [CNT_W:0] t_credit;

    t_reader_state state, state_n;

    logic [ADDR_WIDTH-1:0]      next_addr;
    logic [LEN_WIDTH-1:0]       lines_left;
    logic [LEN_WIDTH-1:0]       lines_total;
    logic [LEN_WIDTH-1:0]       lines_sent;
    logic [CNT_W-1:0]           in_flight;
    logic [CNT_W-1:0]           fifo_count;
    logic [LEN_WIDTH-1:0]       room;
    logic [LEN_WIDTH-1:0]       burst_len_l;
    logic [BURST_CNT_WIDTH-1:0] burst_len;
    t_credit                    free;

    logic job_start;
    logic req_accept;
    logic out_hs;

    // Room to the next aligned boundary never exceeds MAX_BURST, so it also
    // provides the MAX_BURST cap.
    always_comb begin
        room        = LEN_WIDTH'(MAX_BURST) - LEN_WIDTH'(next_addr[BOFF_W-1:0]);
        burst_len_l = (lines_left < room) ? lines_left : room;
        burst_len   = BURST_CNT_WIDTH'(burst_len_l);
        free        = t_credit'(BUF_LINES) - (t_credit'(fifo_count) + t_credit'(in_flight));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // rd_read is a function of registers only; free cannot shrink while a
    // request waits, so the request stays asserted and stable until accepted.
    always_comb begin
        state_n   = state;
        rd_read   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        job_start = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    job_start = 1'b1;
                    state_n   = (num_lines == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                rd_read = (free >= t_credit'(burst_len));
                if (rd_read && !rd_waitrequest && (lines_left == LEN_WIDTH'(burst_len))) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_hs && out_last) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign req_accept = rd_read & ~rd_waitrequest;
    assign out_hs     = out_valid & out_ready;
    assign out_last   = out_valid & ((lines_sent + LEN_WIDTH'(1)) == lines_total);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_addr   <= '0;
            lines_left  <= '0;
            lines_total <= '0;
            lines_sent  <= '0;
            in_flight   <= '0;
        end else begin
            if (job_start) begin
                next_addr   <= start_addr;
                lines_left  <= num_lines;
                lines_total <= num_lines;
                lines_sent  <= '0;
            end else begin
                if (req_accept) begin
                    next_addr  <= next_addr + ADDR_WIDTH'(burst_len);
                    lines_left <= lines_left - LEN_WIDTH'(burst_len);
                end
                if (out_hs) begin
                    lines_sent <= lines_sent + LEN_WIDTH'(1);
                end
            end
            in_flight <= in_flight + (req_accept ? CNT_W'(burst_len) : '0)
                                   - CNT_W'(rd_readdatavalid);
        end
    end

`ifdef HOST_MEM_READER_RSP_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (job_start) begin
            err <= 1'b0;
        end else if (rd_readdatavalid && (rd_response != 2'b00)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_rsp;
    assign unused_rsp = ^rd_response;
    assign err        = 1'b0;
`endif

    assign rd_address    = next_addr;
    assign rd_burstcount = burst_len;
    assign rd_byteenable = '1;
    assign rd_user       = 1'b0;

    host_mem_reader_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_LINES),
        .CNT_WIDTH  (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (rd_readdatavalid),
        .wr_data  (rd_readdata),
        .rd_valid (out_valid),
        .rd_data  (out_data),
        .rd_ready (out_ready),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_host_mem_line_reader.sv
// Self-checking bench for host_mem_line_reader: a host memory model, a
// consumer, and a burst/line reference model computed from address arithmetic.
module tb_host_mem_line_reader;

    localparam int AW = 42;
    localparam int DW = 512;
    localparam int BW = 3;
    localparam int LW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] num_lines = '0;
    logic          busy, done, err;
    logic          rd_read;
    logic [AW-1:0] rd_address;
    logic [BW-1:0] rd_burstcount;
    logic [DW/8-1:0] rd_byteenable;
    logic          rd_user;
    logic          rd_waitrequest = 1'b0;
    logic          rd_readdatavalid = 1'b0;
    logic [DW-1:0] rd_readdata = '0;
    logic [1:0]    rd_response = 2'b00;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    host_mem_line_reader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_addr       (start_addr),
        .num_lines        (num_lines),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .rd_read          (rd_read),
        .rd_address       (rd_address),
        .rd_burstcount    (rd_burstcount),
        .rd_byteenable    (rd_byteenable),
        .rd_user          (rd_user),
        .rd_waitrequest   (rd_waitrequest),
        .rd_readdatavalid (rd_readdatavalid),
        .rd_readdata      (rd_readdata),
        .rd_response      (rd_response),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_ready        (out_ready)
    );

    int checks = 0;
    int errors = 0;

    int wait_pct, gap_pct, ready_pct, ready_block_until, err_beat;
    int cyc, done_cyc, first_rsp_cyc, last_hs_cyc;
    int lines_req, delivered, hold_viol, max_outstanding, beat_idx, req_at_block;
    bit pend_valid;
    logic [AW-1:0] pend_addr;
    logic [BW-1:0] pend_len;

    logic [AW-1:0] rsp_q[$];
    logic [AW-1:0] burst_addr_q[$];
    int            burst_len_q[$];
    logic [DW-1:0] got_data_q[$];
    bit            got_last_q[$];
    bit            busy_h[$], done_h[$], rd_h[$], valid_h[$], err_h[$];

    logic [AW-1:0] exp_addr_q[$];
    int            exp_len_q[$];

    function automatic logic [DW-1:0] line_pattern(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 64; i++) begin
            d[i*64 +: 64] = ({22'h0, a} * 64'(2 * i + 1)) ^ (64'hA5C3_0000_0000_0000 + 64'(i));
        end
        return d;
    endfunction

    // Expected bursts: greedy, capped at 4 lines and at the next 4-line boundary.
    task automatic model_job(input logic [AW-1:0] a0, input int n);
        logic [AW-1:0] a;
        int rem, len, room;
        exp_addr_q.delete();
        exp_len_q.delete();
        a = a0;
        rem = n;
        while (rem > 0) begin
            room = 4 - int'(a % AW'(4));
            len = (rem < room) ? rem : room;
            exp_addr_q.push_back(a);
            exp_len_q.push_back(len);
            a = a + AW'(len);
            rem = rem - len;
        end
    endtask

    task automatic set_env(input int w, input int g, input int r, input int blk, input int eb);
        wait_pct = w;
        gap_pct = g;
        ready_pct = r;
        ready_block_until = blk;
        err_beat = eb;
    endtask

    task automatic clear_log();
        cyc = 0;
        done_cyc = -1;
        first_rsp_cyc = -1;
        last_hs_cyc = -1;
        lines_req = 0;
        delivered = 0;
        hold_viol = 0;
        max_outstanding = 0;
        beat_idx = 0;
        req_at_block = -1;
        pend_valid = 1'b0;
        rsp_q.delete();
        burst_addr_q.delete();
        burst_len_q.delete();
        got_data_q.delete();
        got_last_q.delete();
        busy_h.delete(); done_h.delete(); rd_h.delete(); valid_h.delete(); err_h.delete();
        busy_h.push_back(1'b0); done_h.push_back(1'b0); rd_h.push_back(1'b0);
        valid_h.push_back(1'b0); err_h.push_back(1'b0);
    endtask

    // One cycle of memory model and consumer; observe and drive at negedge.
    task automatic step();
        @(negedge clk);
        cyc++;
        busy_h.push_back(busy);
        done_h.push_back(done);
        rd_h.push_back(rd_read);
        valid_h.push_back(out_valid);
        err_h.push_back(err);

        if (rsp_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            rd_readdatavalid = 1'b1;
            rd_readdata = line_pattern(rsp_q.pop_front());
            rd_response = (beat_idx == err_beat) ? 2'd2 : 2'd0;
            beat_idx++;
            if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
        end else begin
            rd_readdatavalid = 1'b0;
            rd_response = 2'd0;
        end

        rd_waitrequest = ($urandom_range(99) < wait_pct);
        if (rd_read) begin
            if (pend_valid && (rd_address !== pend_addr || rd_burstcount !== pend_len)) hold_viol++;
            if (!rd_waitrequest) begin
                burst_addr_q.push_back(rd_address);
                burst_len_q.push_back(int'(rd_burstcount));
                for (int i = 0; i < int'(rd_burstcount); i++) rsp_q.push_back(rd_address + AW'(i));
                lines_req += int'(rd_burstcount);
                pend_valid = 1'b0;
            end else begin
                pend_valid = 1'b1;
                pend_addr = rd_address;
                pend_len = rd_burstcount;
            end
        end else if (pend_valid) begin
            hold_viol++;
            pend_valid = 1'b0;
        end

        if (cyc <= ready_block_until) out_ready = 1'b0;
        else out_ready = ($urandom_range(99) < ready_pct);
        if (out_valid && out_ready) begin
            got_data_q.push_back(out_data);
            got_last_q.push_back(out_last);
            delivered++;
            last_hs_cyc = cyc;
        end
        if (lines_req - delivered > max_outstanding) max_outstanding = lines_req - delivered;
        if (cyc == ready_block_until) req_at_block = lines_req;
        start = 1'b0;
    endtask

    task automatic run_job(input logic [AW-1:0] a, input int n);
        bit timed_out;
        clear_log();
        start_addr = a;
        num_lines = LW'(n);
        start = 1'b1;
        timed_out = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (done) begin
                timed_out = 1'b0;
                done_cyc = cyc;
                break;
            end
        end
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL job_timeout: addr=%h n=%0d no done within 3000 cycles, delivered %0d", a, n, delivered);
        end else begin
            step();
            step();
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, err, rd_read, out_valid, out_last} !== 6'b0 || rd_address !== '0 || rd_burstcount !== '0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b err=%b rd_read=%b out_valid=%b out_last=%b addr=%h bc=%0d, want all 0",
                     busy, done, err, rd_read, out_valid, out_last, rd_address, rd_burstcount);
        end
        checks++;
        if (rd_byteenable !== {(DW/8){1'b1}} || rd_user !== 1'b0) begin
            errors++;
            $display("FAIL tie_offs: byteenable=%h user=%b, want all ones and 0", rd_byteenable, rd_user);
        end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_aligned();
        int first_valid;
        set_env(0, 0, 100, 0, -1);
        model_job(42'h100, 8);
        run_job(42'h100, 8);
        checks++;
        if (burst_addr_q.size() != exp_addr_q.size()) begin
            errors++;
            $display("FAIL aligned_bursts: got %0d bursts want %0d", burst_addr_q.size(), exp_addr_q.size());
        end else begin
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                checks++;
                if (burst_addr_q[i] !== exp_addr_q[i] || burst_len_q[i] != exp_len_q[i]) begin
                    errors++;
                    $display("FAIL aligned_burst%0d: got %h/%0d want %h/%0d", i, burst_addr_q[i], burst_len_q[i], exp_addr_q[i], exp_len_q[i]);
                end
            end
        end
        checks++;
        if (got_data_q.size() != 8) begin
            errors++;
            $display("FAIL aligned_line_count: got %0d want 8", got_data_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_data_q[i] !== line_pattern(42'h100 + AW'(i)) || got_last_q[i] !== (i == 7)) begin
                    errors++;
                    $display("FAIL aligned_line%0d: data ok=%0b last=%b want last=%b", i,
                             got_data_q[i] === line_pattern(42'h100 + AW'(i)), got_last_q[i], i == 7);
                end
            end
        end
        checks++;
        if (rd_h[1] !== 1'b1 || busy_h[1] !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: cycle1 rd_read=%b busy=%b want 1 1", rd_h[1], busy_h[1]);
        end
        checks++;
        if (done_cyc != last_hs_cyc + 1 || done_h[done_cyc + 1] !== 1'b0 || busy_h[done_cyc + 1] !== 1'b0) begin
            errors++;
            $display("FAIL done_timing: done at %0d last hs %0d, after-done done=%b busy=%b",
                     done_cyc, last_hs_cyc, done_h[done_cyc + 1], busy_h[done_cyc + 1]);
        end
        first_valid = -1;
        for (int i = 0; i < valid_h.size(); i++) begin
            if (valid_h[i] && first_valid < 0) first_valid = i;
        end
        checks++;
        if (first_rsp_cyc < 0 || first_valid != first_rsp_cyc + 1) begin
            errors++;
            $display("FAIL rsp_to_valid: first rsp %0d first out_valid %0d want rsp+1", first_rsp_cyc, first_valid);
        end
        checks++;
        if (done_cyc != 11) begin
            errors++;
            $display("FAIL throughput: done in cycle %0d want 11", done_cyc);
        end
    endtask

    task automatic test_unaligned();
        set_env(0, 0, 100, 0, -1);
        model_job(42'h102, 7);
        run_job(42'h102, 7);
        checks++;
        if (burst_addr_q.size() != 3 || exp_addr_q.size() != 3) begin
            errors++;
            $display("FAIL unaligned_bursts: got %0d bursts want 3", burst_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (burst_addr_q[i] !== exp_addr_q[i] || burst_len_q[i] != exp_len_q[i]) begin
                    errors++;
                    $display("FAIL unaligned_burst%0d: got %h/%0d want %h/%0d", i, burst_addr_q[i], burst_len_q[i], exp_addr_q[i], exp_len_q[i]);
                end
            end
        end
        checks++;
        if (got_data_q.size() != 7 || got_data_q[6] !== line_pattern(42'h108) || got_last_q[6] !== 1'b1) begin
            errors++;
            $display("FAIL unaligned_lines: got %0d lines, want 7 ending at line 0x108 with out_last", got_data_q.size());
        end
    endtask

    task automatic test_backpressure();
        int rd_late;
        set_env(0, 0, 100, 100, -1);
        run_job(42'h1000, 40);
        rd_late = 0;
        for (int i = 30; i <= 100 && i < rd_h.size(); i++) rd_late += int'(rd_h[i]);
        checks++;
        if (req_at_block != 16 || rd_late != 0) begin
            errors++;
            $display("FAIL credit_stall: %0d lines requested while blocked (want 16), rd_read high %0d cycles late (want 0)", req_at_block, rd_late);
        end
        checks++;
        if (got_data_q.size() != 40) begin
            errors++;
            $display("FAIL backpressure_count: got %0d lines want 40", got_data_q.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                if (got_data_q[i] !== line_pattern(42'h1000 + AW'(i)) || got_last_q[i] !== (i == 39)) begin
                    checks++;
                    errors++;
                    $display("FAIL backpressure_line%0d: wrong data or out_last=%b", i, got_last_q[i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_random_stall();
        logic [63:0] r;
        logic [AW-1:0] a;
        int n;
        for (int it = 0; it < 6; it++) begin
            r = {$urandom, $urandom};
            a = r[AW-1:0];
            n = $urandom_range(40, 1);
            set_env(50, 30, 70, 0, -1);
            model_job(a, n);
            run_job(a, n);
            checks++;
            if (hold_viol != 0) begin
                errors++;
                $display("FAIL req_hold_%0d: %0d request changes while stalled, want 0", it, hold_viol);
            end
            checks++;
            if (max_outstanding > 16) begin
                errors++;
                $display("FAIL credits_%0d: %0d lines outstanding, want <= 16", it, max_outstanding);
            end
            checks++;
            if (burst_addr_q.size() != exp_addr_q.size()) begin
                errors++;
                $display("FAIL random_bursts_%0d: got %0d bursts want %0d", it, burst_addr_q.size(), exp_addr_q.size());
            end else begin
                for (int i = 0; i < exp_addr_q.size(); i++) begin
                    if (burst_addr_q[i] !== exp_addr_q[i] || burst_len_q[i] != exp_len_q[i]) begin
                        checks++;
                        errors++;
                        $display("FAIL random_burst_%0d_%0d: got %h/%0d want %h/%0d", it, i,
                                 burst_addr_q[i], burst_len_q[i], exp_addr_q[i], exp_len_q[i]);
                        break;
                    end
                end
            end
            checks++;
            if (got_data_q.size() != n) begin
                errors++;
                $display("FAIL random_count_%0d: got %0d lines want %0d", it, got_data_q.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    if (got_data_q[i] !== line_pattern(a + AW'(i)) || got_last_q[i] !== (i == n - 1)) begin
                        checks++;
                        errors++;
                        $display("FAIL random_line_%0d_%0d: wrong data or out_last=%b", it, i, got_last_q[i]);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic test_resp_err();
        bit exp_err;
        exp_err = 1'b0;
`ifdef HOST_MEM_READER_RSP_ERR_EN
        exp_err = 1'b1;
`endif
        set_env(0, 0, 100, 0, 2);
        run_job(42'h200, 8);
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL resp_err_flag: err=%b want %b", err, exp_err);
        end
        checks++;
        if (got_data_q.size() != 8 || got_data_q[2] !== line_pattern(42'h202) || got_last_q[7] !== 1'b1) begin
            errors++;
            $display("FAIL resp_err_lines: got %0d lines, want 8 including the errored beat", got_data_q.size());
        end
        set_env(0, 0, 100, 0, -1);
        run_job(42'h240, 4);
        checks++;
        if (err_h[1] !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err at cycle1=%b at end=%b, want 0 0", err_h[1], err);
        end
    endtask

    task automatic test_zero_len();
        int rd_cnt;
        set_env(0, 0, 100, 0, -1);
        run_job(42'h300, 0);
        rd_cnt = 0;
        foreach (rd_h[i]) rd_cnt += int'(rd_h[i]);
        checks++;
        if (done_cyc != 1 || rd_cnt != 0 || got_data_q.size() != 0) begin
            errors++;
            $display("FAIL zero_len: done cycle %0d (want 1), rd_read cycles %0d (want 0), lines %0d (want 0)",
                     done_cyc, rd_cnt, got_data_q.size());
        end
        checks++;
        if (busy_h[1] !== 1'b1 || busy_h[2] !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_busy: busy cycle1=%b cycle2=%b want 1 0", busy_h[1], busy_h[2]);
        end
    endtask

    task automatic test_reset_mid_job();
        set_env(20, 10, 60, 0, -1);
        clear_log();
        start_addr = 42'h400;
        num_lines = LW'(40);
        start = 1'b1;
        repeat (15) step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, rd_read, out_valid, out_last} !== 6'b0 || rd_address !== '0 || rd_burstcount !== '0) begin
            errors++;
            $display("FAIL reset_mid_job: busy=%b done=%b err=%b rd_read=%b out_valid=%b out_last=%b addr=%h bc=%0d, want all 0",
                     busy, done, err, rd_read, out_valid, out_last, rd_address, rd_burstcount);
        end
        clear_log();
        rd_readdatavalid = 1'b0;
        rd_waitrequest = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        set_env(20, 10, 80, 0, -1);
        model_job(42'h503, 12);
        run_job(42'h503, 12);
        checks++;
        if (burst_addr_q.size() != exp_addr_q.size() || burst_addr_q[0] !== exp_addr_q[0] || burst_len_q[0] != exp_len_q[0]) begin
            errors++;
            $display("FAIL post_reset_bursts: got %0d bursts want %0d", burst_addr_q.size(), exp_addr_q.size());
        end
        checks++;
        if (got_data_q.size() != 12 || got_data_q[0] !== line_pattern(42'h503) ||
            got_data_q[11] !== line_pattern(42'h50e) || got_last_q[11] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_lines: got %0d lines, want 12 from 0x503 ending with out_last", got_data_q.size());
        end
    endtask

    initial begin
        set_env(0, 0, 100, 0, -1);
        clear_log();
        test_reset();
        test_aligned();
        test_unaligned();
        test_backpressure();
        test_random_stall();
        test_resp_err();
        test_zero_len();
        test_reset_mid_job();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
